// File: rtl/ball_motion.sv
// ball_motion: per-frame ball position/direction update with wall reflection.
// Optional BALL_GRAVITY_EN adds an accelerating vertical speed.
module ball_motion #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int INIT_X   = 400,
  parameter int INIT_Y   = 300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        enable,
  input  logic [2:0]  radius,
  input  logic [2:0]  speed,
  output logic [10:0] ball_x,
  output logic [10:0] ball_y,
  output logic        dir_x,
  output logic        dir_y,
  output logic        bounce
);
  typedef enum logic [1:0] {IDLE, CALC_X, CALC_Y, COMMIT} state_t;
  state_t state_q, state_d;
  logic [10:0] x_q, y_q, nx_q;
  logic dx_q, dy_q, ndx_q, bounce_q, flip_y, ndy;
  logic [2:0] rad_q, spd_q;
  logic [6:0] r;
  logic [11:0] ax, ay;
  logic [3:0] vstep;
`ifdef BALL_GRAVITY_EN
  logic [3:0] vy_q, vy_d;
`endif
  // returns {new_dir, new_pos}; a zero step only clamps into range
  function automatic logic [11:0] step_axis(input logic [10:0] p, input logic d,
      input logic [3:0] s, input logic [6:0] rr, input logic [11:0] hi);
    logic [11:0] n, lim;
    n = d ? {1'b0, p} - {8'd0, s} : {1'b0, p} + {8'd0, s};
    lim = hi - {5'd0, rr};
    if (s == 4'd0) return {d, n > lim ? lim[10:0] : n < {5'd0, rr} ? {4'd0, rr} : n[10:0]};
    if (!d && n > lim) return {1'b1, lim[10:0]};
    if (d && (n[11] || n < {5'd0, rr})) return {1'b0, 4'd0, rr};
    return {d, n[10:0]};
  endfunction
  always_comb begin
    state_d = state_q == IDLE ? (frame_start && enable ? CALC_X : IDLE)
            : state_q == CALC_X ? CALC_Y
            : state_q == CALC_Y ? COMMIT : IDLE;
    r = {1'b0, rad_q, 3'b000} + 7'd8;
    ax = step_axis(x_q, dx_q, {1'b0, spd_q}, r, 12'(H_ACTIVE - 1));
`ifdef BALL_GRAVITY_EN
    vstep = vy_q;
`else
    vstep = {1'b0, spd_q};
`endif
    ay = step_axis(y_q, dy_q, vstep, r, 12'(V_ACTIVE - 1));
    flip_y = ay[11] != dy_q;
`ifdef BALL_GRAVITY_EN
    vy_d = flip_y ? vy_q : !dy_q ? (vy_q == 4'd15 ? vy_q : vy_q + 4'd1) : vy_q - 4'd1;
    ndy = !flip_y && dy_q && vy_d == 4'd0 ? 1'b0 : ay[11];
`else
    ndy = ay[11];
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= 11'(INIT_X);
      y_q      <= 11'(INIT_Y);
      dx_q     <= 1'b0;
      dy_q     <= 1'b0;
      nx_q     <= '0;
      ndx_q    <= 1'b0;
      bounce_q <= 1'b0;
      rad_q    <= '0;
      spd_q    <= '0;
`ifdef BALL_GRAVITY_EN
      vy_q     <= 4'd1;
`endif
    end else begin
      state_q  <= state_d;
      bounce_q <= state_q == CALC_Y && (ndx_q != dx_q || flip_y);
      if (state_q == IDLE && frame_start && enable) begin
        rad_q <= radius;
        spd_q <= speed;
      end
      if (state_q == CALC_X) begin
        nx_q  <= ax[10:0];
        ndx_q <= ax[11];
      end
      if (state_q == CALC_Y) begin
        x_q  <= nx_q;
        dx_q <= ndx_q;
        y_q  <= ay[10:0];
        dy_q <= ndy;
`ifdef BALL_GRAVITY_EN
        vy_q <= vy_d;
`endif
      end
    end
  end
  assign ball_x = x_q;
  assign ball_y = y_q;
  assign dir_x  = dx_q;
  assign dir_y  = dy_q;
  assign bounce = bounce_q;
endmodule

// File: tb/tb_ball_motion.sv
// tb_ball_motion: directed checks of ball_motion; a second 100x100 instance
// is used to reach the top-left corner with both axes moving negative.
module tb_ball_motion;
  logic clk = 0, rst_n = 0, frame_start = 0, fs_c = 0, enable = 1;
  logic [2:0] radius = 0, speed = 0;
  logic [10:0] ball_x, ball_y, cx, cy;
  logic dir_x, dir_y, bounce, cdx, cdy, cb;
  int checks = 0, errors = 0, bcnt = 0, ccnt = 0;

  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bounce) bcnt++;
    if (cb) ccnt++;
  end

  ball_motion dut (.clk(clk), .rst_n(rst_n), .frame_start(frame_start), .enable(enable),
    .radius(radius), .speed(speed), .ball_x(ball_x), .ball_y(ball_y),
    .dir_x(dir_x), .dir_y(dir_y), .bounce(bounce));

  ball_motion #(.H_ACTIVE(100), .V_ACTIVE(100), .INIT_X(50), .INIT_Y(50)) sq (
    .clk(clk), .rst_n(rst_n), .frame_start(fs_c), .enable(enable),
    .radius(radius), .speed(speed), .ball_x(cx), .ball_y(cy),
    .dir_x(cdx), .dir_y(cdy), .bounce(cb));

  task automatic frame(input logic [2:0] s, input logic [2:0] rr);
    @(negedge clk); speed = s; radius = rr; frame_start = 1;
    @(negedge clk); frame_start = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_c(input logic [2:0] s, input logic [2:0] rr);
    @(negedge clk); speed = s; radius = rr; fs_c = 1;
    @(negedge clk); fs_c = 0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (ball_x !== 11'd400) begin errors++; $display("FAIL reset_x got %0d want 400", ball_x); end
    checks++; if (ball_y !== 11'd300) begin errors++; $display("FAIL reset_y got %0d want 300", ball_y); end
    checks++; if ({dir_x, dir_y, bounce} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {dir_x, dir_y, bounce}); end
    @(negedge clk); rst_n = 1;
  endtask

  task automatic test_straight;
    int b0;
    b0 = bcnt;
    repeat (10) frame(3'd3, 3'd0);
    checks++; if (ball_x !== 11'd430) begin errors++; $display("FAIL straight_x got %0d want 430", ball_x); end
    checks++; if (ball_y !== 11'd330) begin errors++; $display("FAIL straight_y got %0d want 330", ball_y); end
    checks++; if ({dir_x, dir_y} !== 2'b00) begin errors++; $display("FAIL straight_dirs got %b want 00", {dir_x, dir_y}); end
    checks++; if (bcnt != b0) begin errors++; $display("FAIL straight_bounce got %0d want 0", bcnt - b0); end
  endtask

  task automatic test_reset_mid;
    int b0;
    @(negedge clk); speed = 3; radius = 0; frame_start = 1;
    @(negedge clk); frame_start = 0;
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    checks++; if (ball_x !== 11'd400) begin errors++; $display("FAIL midrst_x got %0d want 400", ball_x); end
    checks++; if (ball_y !== 11'd300) begin errors++; $display("FAIL midrst_y got %0d want 300", ball_y); end
    checks++; if ({dir_x, dir_y, bounce} !== 3'b000) begin errors++; $display("FAIL midrst_flags got %b want 000", {dir_x, dir_y, bounce}); end
    @(negedge clk); rst_n = 1;
    b0 = bcnt;
    repeat (6) @(negedge clk);
    checks++; if (ball_x !== 11'd400 || ball_y !== 11'd300) begin errors++; $display("FAIL midrst_hold got %0d,%0d want 400,300", ball_x, ball_y); end
    checks++; if (bcnt != b0) begin errors++; $display("FAIL midrst_bounce got %0d want 0", bcnt - b0); end
  endtask

  task automatic test_right_wall;
    int b0;
    b0 = bcnt;
    repeat (55) frame(3'd7, 3'd0);
    frame(3'd3, 3'd0);
    checks++; if (ball_x !== 11'd788 || ball_y !== 11'd497) begin errors++; $display("FAIL wall_setup got %0d,%0d want 788,497", ball_x, ball_y); end
    checks++; if ({dir_x, dir_y} !== 2'b01) begin errors++; $display("FAIL wall_setup_dirs got %b want 01", {dir_x, dir_y}); end
    checks++; if (bcnt - b0 != 1) begin errors++; $display("FAIL bottom_bounce got %0d want 1", bcnt - b0); end
    @(negedge clk); speed = 5; radius = 0; frame_start = 1;
    @(negedge clk); frame_start = 0;
    checks++; if (ball_x !== 11'd788 || bounce !== 1'b0) begin errors++; $display("FAIL wall_c1 got %0d/%b want 788/0", ball_x, bounce); end
    @(negedge clk);
    checks++; if (ball_x !== 11'd788 || bounce !== 1'b0) begin errors++; $display("FAIL wall_c2 got %0d/%b want 788/0", ball_x, bounce); end
    @(negedge clk);
    checks++; if (ball_x !== 11'd791 || dir_x !== 1'b1 || bounce !== 1'b1) begin errors++; $display("FAIL wall_c3 got %0d/%b/%b want 791/1/1", ball_x, dir_x, bounce); end
    checks++; if (ball_y !== 11'd492 || dir_y !== 1'b1) begin errors++; $display("FAIL wall_y got %0d/%b want 492/1", ball_y, dir_y); end
    @(negedge clk);
    checks++; if (bounce !== 1'b0) begin errors++; $display("FAIL wall_pulse got %b want 0", bounce); end
  endtask

  task automatic test_busy_pause;
    int b0;
    @(negedge clk); speed = 2; radius = 0; frame_start = 1;
    @(negedge clk);
    @(negedge clk); frame_start = 0;
    repeat (6) @(negedge clk);
    checks++; if (ball_x !== 11'd789 || ball_y !== 11'd490) begin errors++; $display("FAIL busy got %0d,%0d want 789,490", ball_x, ball_y); end
    b0 = bcnt;
    enable = 0;
    frame(3'd5, 3'd0);
    checks++; if (ball_x !== 11'd789 || ball_y !== 11'd490) begin errors++; $display("FAIL pause got %0d,%0d want 789,490", ball_x, ball_y); end
    checks++; if (bcnt != b0) begin errors++; $display("FAIL pause_bounce got %0d want 0", bcnt - b0); end
    enable = 1;
  endtask

  task automatic test_radius_clamp;
    int b0;
    b0 = bcnt;
    frame(3'd0, 3'd7);
    checks++; if (ball_x !== 11'd735 || dir_x !== 1'b1) begin errors++; $display("FAIL clamp_x got %0d/%b want 735/1", ball_x, dir_x); end
    checks++; if (ball_y !== 11'd490 || dir_y !== 1'b1) begin errors++; $display("FAIL clamp_y got %0d/%b want 490/1", ball_y, dir_y); end
    checks++; if (bcnt != b0) begin errors++; $display("FAIL clamp_bounce got %0d want 0", bcnt - b0); end
  endtask

  task automatic test_corner;
    int c0;
    repeat (6) frame_c(3'd7, 3'd0);
    repeat (11) frame_c(3'd7, 3'd0);
    frame_c(3'd6, 3'd0);
    checks++; if (cx !== 11'd8 || cy !== 11'd8 || {cdx, cdy} !== 2'b11) begin errors++; $display("FAIL corner_setup got %0d,%0d/%b want 8,8/11", cx, cy, {cdx, cdy}); end
    c0 = ccnt;
    frame_c(3'd4, 3'd0);
    checks++; if (cx !== 11'd8 || cy !== 11'd8) begin errors++; $display("FAIL corner_pos got %0d,%0d want 8,8", cx, cy); end
    checks++; if ({cdx, cdy} !== 2'b00) begin errors++; $display("FAIL corner_dirs got %b want 00", {cdx, cdy}); end
    checks++; if (ccnt - c0 != 1) begin errors++; $display("FAIL corner_bounce got %0d want 1", ccnt - c0); end
  endtask

  task automatic test_gravity;
    repeat (3) frame(3'd0, 3'd0);
    checks++; if (ball_y !== 11'd306 || ball_x !== 11'd400) begin errors++; $display("FAIL gravity3 got %0d,%0d want 400,306", ball_x, ball_y); end
    frame(3'd0, 3'd0);
    checks++; if (ball_y !== 11'd310) begin errors++; $display("FAIL gravity4 got %0d want 310", ball_y); end
  endtask

  initial begin
    test_reset;
`ifdef BALL_GRAVITY_EN
    test_gravity;
`else
    test_straight;
    test_reset_mid;
    test_right_wall;
    test_busy_pause;
    test_radius_clamp;
    test_corner;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
